// File: rtl/alu_result_stage.sv
// Result stage after the add/sub-with-overflow unit. It holds up to two results
// with their {N,Z,V} flags and commits those flags to the status register.
module alu_result_stage #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_s,
  input  logic         in_ovf,
  input  logic         in_ld_status,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_c,
  output logic [2:0]   out_flags,
  output logic [2:0]   status,
  output logic [1:0]   occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   head_s_q, head_s_d, tail_s_q, tail_s_d;
  logic [2:0]     head_f_q, head_f_d, tail_f_q, tail_f_d;
  logic           head_ld_q, head_ld_d, tail_ld_q, tail_ld_d;
  logic [2:0]     status_q, status_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic           in_fire, out_fire;
  logic [2:0]     in_flags;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;
  assign in_flags = {in_s[N-1], (in_s == '0), in_ovf};

  // The head slot always holds the oldest entry; the tail slot is only used in FULL.
  always_comb begin
    state_d   = state_q;
    head_s_d  = head_s_q;
    head_f_d  = head_f_q;
    head_ld_d = head_ld_q;
    tail_s_d  = tail_s_q;
    tail_f_d  = tail_f_q;
    tail_ld_d = tail_ld_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          head_s_d  = in_s;
          head_f_d  = in_flags;
          head_ld_d = in_ld_status;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          head_s_d  = in_s;
          head_f_d  = in_flags;
          head_ld_d = in_ld_status;
        end else if (in_fire) begin
          tail_s_d  = in_s;
          tail_f_d  = in_flags;
          tail_ld_d = in_ld_status;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d   = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          head_s_d  = tail_s_q;
          head_f_d  = tail_f_q;
          head_ld_d = tail_ld_q;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Ready and valid are registered from the next state so out_ready never reaches in_ready.
  always_comb begin
    status_d    = (out_fire && head_ld_q) ? head_f_q : status_q;
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_s_q    <= '0;
      head_f_q    <= '0;
      head_ld_q   <= 1'b0;
      tail_s_q    <= '0;
      tail_f_q    <= '0;
      tail_ld_q   <= 1'b0;
      status_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_s_q    <= head_s_d;
      head_f_q    <= head_f_d;
      head_ld_q   <= head_ld_d;
      tail_s_q    <= tail_s_d;
      tail_f_q    <= tail_f_d;
      tail_ld_q   <= tail_ld_d;
      status_q    <= status_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_c     = head_s_q;
  assign out_flags = head_f_q;
  assign status    = status_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the result stage.
module tb_alu_result_stage;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_s = '0;
  logic         in_ovf = 1'b0;
  logic         in_ld_status = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_c;
  logic [2:0]   out_flags;
  logic [2:0]   status;
  logic [1:0]   occupancy;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  alu_result_stage #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_ovf(in_ovf), .in_ld_status(in_ld_status),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_flags(out_flags),
    .status(status), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] s;
    logic [2:0]   f;
    logic         ld;
  } ent_t;

  ent_t       mq[$];
  logic [2:0] m_status;
  bit         m_ready_ok;
  bit         m_fresh;
  bit         m_in_fire, m_out_fire;
  ent_t       m_e;

  // Reference: a queue of at most two entries; status copies a leaving entry's flags if it asked to.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_status   = 3'b000;
      m_ready_ok = 1'b0;
      m_fresh    = 1'b1;
    end else begin
      m_in_fire  = in_valid && m_ready_ok && (mq.size() < 2);
      m_out_fire = out_ready && (mq.size() > 0);
      if (m_out_fire) begin
        m_e = mq.pop_front();
        if (m_e.ld) m_status = m_e.f;
      end
      if (m_in_fire) begin
        m_e.s  = in_s;
        m_e.f  = {in_s[N-1], (in_s == 0), in_ovf};
        m_e.ld = in_ld_status;
        mq.push_back(m_e);
        m_fresh = 1'b0;
      end
      m_ready_ok = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("occupancy", {30'd0, occupancy}, mq.size());
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (m_ready_ok && mq.size() < 2)});
      checkOutput("status", {29'd0, status}, {29'd0, m_status});
      if (mq.size() > 0) begin
        checkOutput("out_c", {16'd0, out_c}, {16'd0, mq[0].s});
        checkOutput("out_flags", {29'd0, out_flags}, {29'd0, mq[0].f});
      end else if (m_fresh) begin
        checkOutput("out_c_reset", {16'd0, out_c}, 32'd0);
        checkOutput("out_flags_reset", {29'd0, out_flags}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [N-1:0] s, input logic ovf,
                               input logic ld, input logic ordy);
    in_valid     = v;
    in_s         = s;
    in_ovf       = ovf;
    in_ld_status = ld;
    out_ready    = ordy;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_en = 1'b1;
    #1;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_occupancy", {30'd0, occupancy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkOutput("ready_after_release", {31'd0, in_ready}, 32'd1);

    // Zero result with status load
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("s1_out_c", {16'd0, out_c}, 32'h0000);
    checkOutput("s1_flags", {29'd0, out_flags}, 32'b010);
    step();
    checkOutput("s1_status", {29'd0, status}, 32'b010);

    // 0x7FFF+1 overflow
    applyStimulus(1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("s2_flags", {29'd0, out_flags}, 32'b101);
    out_ready = 1'b1;
    step();
    checkOutput("s2_status", {29'd0, status}, 32'b101);
    checkOutput("s2_occupancy", {30'd0, occupancy}, 32'd0);

    // A, B, C back to back into a stalled stage
    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("s3_occupancy_full", {30'd0, occupancy}, 32'd2);
    checkOutput("s3_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("s3_head_a", {16'd0, out_c}, 32'h1111);
    out_ready = 1'b1;
    step();
    checkOutput("s3_head_b", {16'd0, out_c}, 32'h2222);
    step();
    checkOutput("s4_occupancy_one", {30'd0, occupancy}, 32'd1);
    checkOutput("s4_head_c", {16'd0, out_c}, 32'h3333);
    in_valid = 1'b0;
    step();
    checkOutput("s3_drained", {30'd0, occupancy}, 32'd0);

    // Zero result without status load
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    checkOutput("s5_flags", {29'd0, out_flags}, 32'b011);
    step();
    checkOutput("s5_status_held", {29'd0, status}, 32'b101);

    // Reset while full
    applyStimulus(1'b1, 16'h8001, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("s6_full", {30'd0, occupancy}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("s6_occupancy", {30'd0, occupancy}, 32'd0);
    checkOutput("s6_status", {29'd0, status}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    checkOutput("s6_no_stale", {31'd0, out_valid}, 32'd0);

    // Random traffic, with corner data values mixed in
    for (int i = 0; i < 800; i++) begin
      logic [N-1:0] s;
      case ($urandom_range(0, 5))
        0: s = 16'h0000;
        1: s = 16'h8000;
        2: s = 16'h7FFF;
        default: s = N'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 3) != 0), s, 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 2) != 0));
      if (i == 400) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: N, default 16, width of the data path carried from the add/subtract-with-overflow stage.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream add/sub result is valid this cycle.
REQ-005 in_ready  output  1  stage can accept an entry this cycle.
REQ-006 in_s  input  N  sum or difference from the upstream adder/subtractor.
REQ-007 in_ovf  input  1  signed-overflow flag from the upstream adder/subtractor.
REQ-008 in_ld_status  input  1  this operation updates the status register.
REQ-009 out_valid  output  1  head entry is presented downstream.
REQ-010 out_ready  input  1  downstream accepts the head entry this cycle.
REQ-011 out_c  output  N  registered result of the head entry.
REQ-012 out_flags  output  3  {N,Z,V} of the head entry.
REQ-013 status  output  3  architectural status register {N,Z,V}.
REQ-014 occupancy  output  2  number of held entries, 0..2.

Function
REQ-015 The stage SHALL be a 2-entry FIFO/skid buffer with states EMPTY (occupancy 0), ONE (1) and FULL (2).
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, driven only from registered state with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 exactly when occupancy is nonzero.
REQ-019 Entry flags SHALL be computed at input transfer:
- N = in_s[N-1]
- Z = (in_s == 0)
- V = in_ovf
REQ-020 Flags SHALL be stored with the entry alongside in_s and in_ld_status.
REQ-021 Latency SHALL be 1 cycle: an entry accepted at edge k into EMPTY SHALL appear on out_c/out_flags after edge k.
REQ-022 Entries SHALL leave in acceptance order; data and flags SHALL NOT change while out_valid && !out_ready.
REQ-023 State transitions:
- EMPTY: input transfer -> ONE.
- ONE: input transfer only -> FULL; output transfer only -> EMPTY; simultaneous input and output transfer -> ONE, with the new entry becoming the head.
- FULL: output transfer -> ONE, with the second entry becoming the head; no input is accepted.
REQ-024 status SHALL be written with the head entry's flags on an output transfer whose stored ld_status is 1, and SHALL hold otherwise.
REQ-025 Input while FULL (in_valid with in_ready=0) SHALL be ignored with no state change; upstream holds the entry.
REQ-026 out_ready asserted while EMPTY SHALL have no effect.
REQ-027 Result width SHALL be exactly N bits, with no extension or truncation of in_s.
REQ-028 Flag examples:
- 0x8000 with N=16 gives N=1, Z=0.
- 0x0000 gives Z=1 regardless of V.
- V SHALL be passed through unchanged.

Reset
REQ-029 rst_n low SHALL asynchronously force the following:
- occupancy=0, state EMPTY
- out_valid=0
- out_c=0, out_flags=0
- status=3'b000
- in_ready=0
REQ-030 in_ready SHALL become 1 on the first rising clk edge after rst_n deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all held entries without updating status.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Reset, then in_s=0x0000, in_ovf=0, ld_status=1, out_ready=1 -> next cycle out_c=0x0000, out_flags=010; status=010 after the output transfer.
- in_s=0x8000, in_ovf=1 (0x7FFF+1), ld_status=1 -> out_flags=101; status=101 after consumption.
- out_ready=0, three back-to-back inputs A, B, C -> A and B accepted, occupancy=2, in_ready=0, C held; then out_ready=1 -> outputs A, B, C in order.
- Occupancy 1 with simultaneous input and output transfer -> occupancy stays 1, next head = new entry, no lost or duplicated entry.
- Entry with ld_status=0 and in_s=0 consumed -> out_flags Z=1, status unchanged from prior value.
- rst_n pulsed low while FULL -> out_valid=0 and occupancy=0 immediately, status=000, and no stale entry emerges after release.
